// File: rtl/noc_response_axi_wide.sv
// NoC response to AXI R/B converter: turns L2 response messages (header + 64-bit payload flits)
// into AXI read-data beats and write responses, matched in order against pushed transaction info.

module noc_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module noc_response_axi_wide #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int TXN_DEPTH      = 16,
    parameter int RDATA_DEPTH    = 16,
    parameter int B_DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      noc_valid_in,
    input  logic [63:0]               noc_data_in,
    output logic                      noc_ready_out,
    input  logic                      txn_valid,
    output logic                      txn_ready,
    input  logic [AXI_ID_WIDTH-1:0]   txn_id,
    input  logic                      txn_is_store,
    input  logic                      txn_last,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    output logic [1:0]                m_axi_rresp,
    output logic                      m_axi_rlast,
    output logic                      m_axi_rvalid,
    input  logic                      m_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
    output logic [1:0]                m_axi_bresp,
    output logic                      m_axi_bvalid,
    input  logic                      m_axi_bready,
    output logic                      idle,
    output logic                      err_unexpected
);
    localparam int F        = AXI_DATA_WIDTH / 64;
    localparam int IDW      = AXI_ID_WIDTH;
    localparam int LEN_W    = 8;
    localparam int TXN_W    = IDW + 2;
    localparam int R_W      = IDW + AXI_DATA_WIDTH + 3;
    localparam int B_W      = IDW + 2;
    localparam logic [7:0] DATA_ACK   = 8'd36;
    localparam logic [7:0] NODATA_ACK = 8'd37;

    typedef enum logic [1:0] {HDR, RD, ST, DROP} state_t;

    state_t state, state_next;

    logic [LEN_W-1:0]          cnt, len_q, hdr_len;
    logic [7:0]                hdr_type;
    logic [1:0]                hdr_resp, cur_resp;
    logic [IDW-1:0]            cur_id, head_id;
    logic                      cur_last, head_store, head_last;
    logic [AXI_DATA_WIDTH-1:0] beat_q, beat_next;
    logic [31:0]               slot;
    logic                      final_flit, beat_done, hdr_b_now, flit_fire;

    logic             txn_full, txn_empty, txn_pop;
    logic [TXN_W-1:0] txn_head;
    logic             r_push, r_full, r_empty;
    logic [R_W-1:0]   r_wdata, r_head;
    logic             b_push, b_full, b_empty;
    logic [B_W-1:0]   b_wdata, b_head;

    function automatic logic [63:0] swendian64(input logic [63:0] d);
        logic [63:0] s;
        for (int i = 0; i < 8; i++) begin
            s[i*8 +: 8] = d[(7-i)*8 +: 8];
        end
        return s;
    endfunction

    // Header fields follow the L2 NoC layout: length in [29:22], message type in [21:14].
    assign hdr_len  = noc_data_in[29:22];
    assign hdr_type = noc_data_in[21:14];
    assign hdr_resp = (hdr_type == DATA_ACK || hdr_type == NODATA_ACK) ? 2'b00 : 2'b10;

    assign {head_id, head_store, head_last} = txn_head;
    assign hdr_b_now  = !txn_empty && head_store && head_last && (hdr_len == '0);
    assign final_flit = (cnt == len_q - 8'd1);
    assign slot       = 32'(cnt) % 32'(F);
    assign beat_done  = (slot == 32'(F - 1)) || final_flit;
    assign flit_fire  = noc_valid_in && noc_ready_out;

    // Slots above the current flit are still zero, so a short final beat comes out padded.
    always_comb begin
        beat_next = beat_q;
        beat_next[slot*64 +: 64] = swendian64(noc_data_in);
    end

    assign r_wdata = {cur_id, beat_next, cur_resp, cur_last && final_flit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HDR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR: begin
                if (flit_fire) begin
                    if (txn_empty)          state_next = (hdr_len != '0) ? DROP : HDR;
                    else if (hdr_len == '0) state_next = HDR;
                    else if (head_store)    state_next = ST;
                    else                    state_next = RD;
                end
            end
            RD, ST, DROP: begin
                if (flit_fire && final_flit) state_next = HDR;
            end
            default: state_next = HDR;
        endcase
    end

    // Flow control stalls only the flit that actually needs space in a full output FIFO.
    always_comb begin
        noc_ready_out = 1'b0;
        txn_pop       = 1'b0;
        r_push        = 1'b0;
        b_push        = 1'b0;
        b_wdata       = {cur_id, cur_resp};
        case (state)
            HDR: begin
                noc_ready_out = !(hdr_b_now && b_full);
                txn_pop       = noc_valid_in && !(hdr_b_now && b_full) && !txn_empty;
                b_push        = noc_valid_in && !b_full && hdr_b_now;
                b_wdata       = {head_id, hdr_resp};
            end
            RD: begin
                noc_ready_out = !(beat_done && r_full);
                r_push        = noc_valid_in && beat_done && !r_full;
            end
            ST: begin
                noc_ready_out = !(final_flit && cur_last && b_full);
                b_push        = noc_valid_in && final_flit && cur_last && !b_full;
            end
            DROP: noc_ready_out = 1'b1;
            default: noc_ready_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            len_q          <= '0;
            cur_id         <= '0;
            cur_last       <= 1'b0;
            cur_resp       <= 2'b00;
            beat_q         <= '0;
            err_unexpected <= 1'b0;
        end else if (state == HDR) begin
            cnt    <= '0;
            beat_q <= '0;
            if (flit_fire) begin
                len_q    <= hdr_len;
                cur_id   <= head_id;
                cur_last <= head_last;
                cur_resp <= hdr_resp;
                if (txn_empty) err_unexpected <= 1'b1;
            end
        end else if (flit_fire) begin
            cnt <= cnt + 1'b1;
            if (state == RD) beat_q <= beat_done ? '0 : beat_next;
        end
    end

    // A full txn FIFO still accepts a new entry in the cycle its head is consumed.
    assign txn_ready = !txn_full || txn_pop;

    noc_resp_fifo #(.WIDTH(TXN_W), .DEPTH(TXN_DEPTH)) u_txn_fifo (
        .clk(clk), .rst(rst), .push(txn_valid && txn_ready),
        .wdata({txn_id, txn_is_store, txn_last}), .pop(txn_pop),
        .rdata(txn_head), .full(txn_full), .empty(txn_empty)
    );

    noc_resp_fifo #(.WIDTH(R_W), .DEPTH(RDATA_DEPTH)) u_r_fifo (
        .clk(clk), .rst(rst), .push(r_push), .wdata(r_wdata),
        .pop(m_axi_rvalid && m_axi_rready), .rdata(r_head), .full(r_full), .empty(r_empty)
    );

    noc_resp_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk(clk), .rst(rst), .push(b_push), .wdata(b_wdata),
        .pop(m_axi_bvalid && m_axi_bready), .rdata(b_head), .full(b_full), .empty(b_empty)
    );

    // Payload outputs read as zero whenever their channel has nothing valid to present.
    assign m_axi_rvalid = !r_empty;
    assign {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = r_empty ? '0 : r_head;
    assign m_axi_bvalid = !b_empty;
    assign {m_axi_bid, m_axi_bresp} = b_empty ? '0 : b_head;

    assign idle = txn_empty && r_empty && b_empty && (state == HDR);
endmodule

// File: tb/tb_noc_response_axi_wide.sv
// Directed bench: a 64-bit instance for the main paths and a 128-bit instance with a
// two-entry R FIFO for multi-flit beats and NoC backpressure.

module tb_noc_response_axi_wide;
    localparam logic [7:0]  DATA_ACK   = 8'd36;
    localparam logic [7:0]  NODATA_ACK = 8'd37;
    localparam logic [7:0]  BAD_TYPE   = 8'h55;
    localparam logic [63:0] FA = 64'h0123456789ABCDEF, SA = 64'hEFCDAB8967452301;
    localparam logic [63:0] FB = 64'h1122334455667788, SB = 64'h8877665544332211;
    localparam logic [63:0] FC = 64'hDEADBEEF00000001, SC = 64'h01000000EFBEADDE;
    localparam logic [63:0] FD = 64'hCAFEF00D12345678, SD = 64'h785634120DF0FECA;
    localparam logic [63:0] FE = 64'h0000000000000AAA, SE = 64'hAA0A000000000000;
    localparam logic [63:0] FF = 64'hFFEEDDCCBBAA9988, SF = 64'h8899AABBCCDDEEFF;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    logic        a_noc_valid, a_noc_ready, a_txn_valid, a_txn_ready, a_txn_store, a_txn_last;
    logic [63:0] a_noc_data, a_rdata;
    logic [3:0]  a_txn_id, a_rid, a_bid;
    logic [1:0]  a_rresp, a_bresp;
    logic        a_rlast, a_rvalid, a_rready, a_bvalid, a_bready, a_idle, a_err;

    logic         w_noc_valid, w_noc_ready, w_txn_valid, w_txn_ready, w_txn_store, w_txn_last;
    logic [63:0]  w_noc_data;
    logic [127:0] w_rdata;
    logic [3:0]   w_txn_id, w_rid, w_bid;
    logic [1:0]   w_rresp, w_bresp;
    logic         w_rlast, w_rvalid, w_rready, w_bvalid, w_bready, w_idle, w_err;

    noc_response_axi_wide #(.AXI_DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .noc_valid_in(a_noc_valid), .noc_data_in(a_noc_data), .noc_ready_out(a_noc_ready),
        .txn_valid(a_txn_valid), .txn_ready(a_txn_ready), .txn_id(a_txn_id),
        .txn_is_store(a_txn_store), .txn_last(a_txn_last),
        .m_axi_rid(a_rid), .m_axi_rdata(a_rdata), .m_axi_rresp(a_rresp), .m_axi_rlast(a_rlast),
        .m_axi_rvalid(a_rvalid), .m_axi_rready(a_rready),
        .m_axi_bid(a_bid), .m_axi_bresp(a_bresp), .m_axi_bvalid(a_bvalid), .m_axi_bready(a_bready),
        .idle(a_idle), .err_unexpected(a_err)
    );

    noc_response_axi_wide #(.AXI_DATA_WIDTH(128), .RDATA_DEPTH(2)) dut_wide (
        .clk(clk), .rst(rst),
        .noc_valid_in(w_noc_valid), .noc_data_in(w_noc_data), .noc_ready_out(w_noc_ready),
        .txn_valid(w_txn_valid), .txn_ready(w_txn_ready), .txn_id(w_txn_id),
        .txn_is_store(w_txn_store), .txn_last(w_txn_last),
        .m_axi_rid(w_rid), .m_axi_rdata(w_rdata), .m_axi_rresp(w_rresp), .m_axi_rlast(w_rlast),
        .m_axi_rvalid(w_rvalid), .m_axi_rready(w_rready),
        .m_axi_bid(w_bid), .m_axi_bresp(w_bresp), .m_axi_bvalid(w_bvalid), .m_axi_bready(w_bready),
        .idle(w_idle), .err_unexpected(w_err)
    );

    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [7:0] typ);
        return {34'd0, len, typ, 14'd0};
    endfunction

    task automatic send_a(input logic [63:0] d);
        int n = 0;
        a_noc_valid = 1'b1;
        a_noc_data  = d;
        @(negedge clk);
        while (!a_noc_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_noc_ready) begin
            vectors++; miscompares++;
            $display("[TB] FAIL send_a_timeout: noc_ready_out=%b, required 1", a_noc_ready);
        end
        @(posedge clk); #1;
        a_noc_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d);
        int n = 0;
        w_noc_valid = 1'b1;
        w_noc_data  = d;
        @(negedge clk);
        while (!w_noc_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!w_noc_ready) begin
            vectors++; miscompares++;
            $display("[TB] FAIL send_w_timeout: noc_ready_out=%b, required 1", w_noc_ready);
        end
        @(posedge clk); #1;
        w_noc_valid = 1'b0;
    endtask

    task automatic push_txn_a(input logic [3:0] id, input logic store, input logic last);
        a_txn_valid = 1'b1; a_txn_id = id; a_txn_store = store; a_txn_last = last;
        @(posedge clk); #1;
        a_txn_valid = 1'b0;
    endtask

    task automatic push_txn_w(input logic [3:0] id, input logic store, input logic last);
        w_txn_valid = 1'b1; w_txn_id = id; w_txn_store = store; w_txn_last = last;
        @(posedge clk); #1;
        w_txn_valid = 1'b0;
    endtask

    // Samples the R head as {rvalid, rid, rresp, rlast, rdata}, then handshakes it away.
    task automatic pop_a(output logic [71:0] obs);
        @(negedge clk);
        obs = {a_rvalid, a_rid, a_rresp, a_rlast, a_rdata};
        a_rready = 1'b1;
        @(posedge clk); #1;
        a_rready = 1'b0;
    endtask

    task automatic pop_w(output logic [135:0] obs);
        @(negedge clk);
        obs = {w_rvalid, w_rid, w_rresp, w_rlast, w_rdata};
        w_rready = 1'b1;
        @(posedge clk); #1;
        w_rready = 1'b0;
    endtask

    task automatic test_reset;
        logic [82:0] obs;
        logic [82:0] exp_v;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 2'b00, 64'd0};
        obs = {a_rvalid, a_bvalid, a_idle, a_txn_ready, a_err, a_noc_ready, a_rid, a_bid,
               a_rresp, a_bresp, a_rdata};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL reset_state_64: got %h, required %h", obs, exp_v);
        end
        obs = {w_rvalid, w_bvalid, w_idle, w_txn_ready, w_err, w_noc_ready, w_rid, w_bid,
               w_rresp, w_bresp, w_rdata[63:0]};
        vectors++;
        if (obs !== exp_v || w_rdata[127:64] !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state_128: got %h, required %h", obs, exp_v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load64;
        logic [71:0] obs;
        push_txn_a(4'd3, 1'b0, 1'b1);
        send_a(hdr(8'd2, DATA_ACK));
        send_a(FA);
        send_a(FB);
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd3, 2'b00, 1'b0, SA}) begin
            miscompares++;
            $display("[TB] FAIL load64_beat0: got %h, required %h", obs, {1'b1, 4'd3, 2'b00, 1'b0, SA});
        end
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd3, 2'b00, 1'b1, SB}) begin
            miscompares++;
            $display("[TB] FAIL load64_beat1: got %h, required %h", obs, {1'b1, 4'd3, 2'b00, 1'b1, SB});
        end
        @(negedge clk);
        vectors++;
        if ({a_rvalid, a_idle} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL load64_drained: rvalid,idle=%b, required 01", {a_rvalid, a_idle});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store;
        push_txn_a(4'd5, 1'b1, 1'b1);
        send_a(hdr(8'd1, NODATA_ACK));
        @(negedge clk);
        vectors++;
        if (a_bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_early_bvalid: bvalid=%b, required 0", a_bvalid);
        end
        a_bready = 1'b0;
        send_a(FC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({a_bvalid, a_bid, a_bresp} !== {1'b1, 4'd5, 2'b00}) begin
                miscompares++;
                $display("[TB] FAIL store_b_hold[%0d]: bvalid,bid,bresp=%b, required %b",
                         i, {a_bvalid, a_bid, a_bresp}, {1'b1, 4'd5, 2'b00});
            end
        end
        @(posedge clk); #1;
        a_bready = 1'b1;
        @(posedge clk); #1;
        a_bready = 1'b0;
        @(negedge clk);
        vectors++;
        if (a_bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_b_pop: bvalid=%b, required 0", a_bvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_type;
        logic [71:0] obs;
        push_txn_a(4'd7, 1'b0, 1'b1);
        send_a(hdr(8'd2, BAD_TYPE));
        send_a(FA);
        send_a(FB);
        push_txn_a(4'd8, 1'b0, 1'b1);
        send_a(hdr(8'd1, DATA_ACK));
        send_a(FC);
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd7, 2'b10, 1'b0, SA}) begin
            miscompares++;
            $display("[TB] FAIL badtype_beat0: got %h, required %h", obs, {1'b1, 4'd7, 2'b10, 1'b0, SA});
        end
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd7, 2'b10, 1'b1, SB}) begin
            miscompares++;
            $display("[TB] FAIL badtype_beat1: got %h, required %h", obs, {1'b1, 4'd7, 2'b10, 1'b1, SB});
        end
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd8, 2'b00, 1'b1, SC}) begin
            miscompares++;
            $display("[TB] FAIL badtype_next_okay: got %h, required %h", obs, {1'b1, 4'd8, 2'b00, 1'b1, SC});
        end
    endtask

    task automatic test_unexpected;
        logic [71:0] obs;
        send_a(hdr(8'd3, DATA_ACK));
        send_a(FA);
        send_a(FB);
        send_a(FC);
        @(negedge clk);
        vectors++;
        if ({a_err, a_rvalid, a_bvalid, a_idle} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL unexpected_drop: err,rvalid,bvalid,idle=%b, required 1001",
                     {a_err, a_rvalid, a_bvalid, a_idle});
        end
        @(posedge clk); #1;
        push_txn_a(4'd2, 1'b0, 1'b1);
        send_a(hdr(8'd1, DATA_ACK));
        send_a(FD);
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd2, 2'b00, 1'b1, SD}) begin
            miscompares++;
            $display("[TB] FAIL unexpected_next_msg: got %h, required %h", obs, {1'b1, 4'd2, 2'b00, 1'b1, SD});
        end
        vectors++;
        if (a_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL unexpected_sticky: err_unexpected=%b, required 1", a_err);
        end
    endtask

    task automatic test_back_to_back;
        logic [71:0] obs;
        push_txn_a(4'd4, 1'b0, 1'b0);
        push_txn_a(4'd4, 1'b0, 1'b1);
        send_a(hdr(8'd1, DATA_ACK));
        send_a(FE);
        send_a(hdr(8'd1, DATA_ACK));
        send_a(FF);
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd4, 2'b00, 1'b0, SE}) begin
            miscompares++;
            $display("[TB] FAIL b2b_not_last: got %h, required %h", obs, {1'b1, 4'd4, 2'b00, 1'b0, SE});
        end
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd4, 2'b00, 1'b1, SF}) begin
            miscompares++;
            $display("[TB] FAIL b2b_last: got %h, required %h", obs, {1'b1, 4'd4, 2'b00, 1'b1, SF});
        end
        push_txn_a(4'd6, 1'b1, 1'b0);
        send_a(hdr(8'd1, NODATA_ACK));
        send_a(FA);
        @(negedge clk);
        vectors++;
        if ({a_bvalid, a_idle} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL store_not_last_no_b: bvalid,idle=%b, required 01", {a_bvalid, a_idle});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wide_backpressure;
        logic [135:0] obs;
        push_txn_w(4'd1, 1'b0, 1'b1);
        push_txn_w(4'd2, 1'b0, 1'b1);
        send_w(hdr(8'd4, DATA_ACK));
        send_w(FA);
        send_w(FB);
        send_w(FC);
        send_w(FD);
        send_w(hdr(8'd2, DATA_ACK));
        send_w(FE);
        w_noc_valid = 1'b1;
        w_noc_data  = FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (w_noc_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL wide_stall[%0d]: noc_ready_out=%b, required 0", i, w_noc_ready);
            end
        end
        @(posedge clk); #1;
        pop_w(obs);
        vectors++;
        if (obs !== {1'b1, 4'd1, 2'b00, 1'b0, SB, SA}) begin
            miscompares++;
            $display("[TB] FAIL wide_beat0: got %h, required %h", obs, {1'b1, 4'd1, 2'b00, 1'b0, SB, SA});
        end
        @(negedge clk);
        vectors++;
        if (w_noc_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wide_resume: noc_ready_out=%b, required 1", w_noc_ready);
        end
        @(posedge clk); #1;
        w_noc_valid = 1'b0;
        pop_w(obs);
        vectors++;
        if (obs !== {1'b1, 4'd1, 2'b00, 1'b1, SD, SC}) begin
            miscompares++;
            $display("[TB] FAIL wide_beat1: got %h, required %h", obs, {1'b1, 4'd1, 2'b00, 1'b1, SD, SC});
        end
        pop_w(obs);
        vectors++;
        if (obs !== {1'b1, 4'd2, 2'b00, 1'b1, SF, SE}) begin
            miscompares++;
            $display("[TB] FAIL wide_beat2: got %h, required %h", obs, {1'b1, 4'd2, 2'b00, 1'b1, SF, SE});
        end
        @(negedge clk);
        vectors++;
        if ({w_rvalid, w_idle} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL wide_drained: rvalid,idle=%b, required 01", {w_rvalid, w_idle});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_message;
        logic [71:0] obs;
        push_txn_a(4'd9, 1'b0, 1'b1);
        send_a(hdr(8'd2, DATA_ACK));
        send_a(FA);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({a_rvalid, a_idle, a_err, a_txn_ready, a_noc_ready} !== 5'b01011) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: rvalid,idle,err,txn_ready,noc_ready=%b, required 01011",
                     {a_rvalid, a_idle, a_err, a_txn_ready, a_noc_ready});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        push_txn_a(4'd10, 1'b0, 1'b1);
        send_a(hdr(8'd1, DATA_ACK));
        send_a(FB);
        pop_a(obs);
        vectors++;
        if (obs !== {1'b1, 4'd10, 2'b00, 1'b1, SB}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_next_msg: got %h, required %h", obs, {1'b1, 4'd10, 2'b00, 1'b1, SB});
        end
    endtask

    initial begin
        rst = 1'b1;
        a_noc_valid = 1'b0; a_noc_data = '0; a_txn_valid = 1'b0; a_txn_id = '0;
        a_txn_store = 1'b0; a_txn_last = 1'b0; a_rready = 1'b0; a_bready = 1'b0;
        w_noc_valid = 1'b0; w_noc_data = '0; w_txn_valid = 1'b0; w_txn_id = '0;
        w_txn_store = 1'b0; w_txn_last = 1'b0; w_rready = 1'b0; w_bready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load64();
        test_store();
        test_bad_type();
        test_unexpected();
        test_back_to_back();
        test_wide_backpressure();
        test_reset_mid_message();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
